// File: rtl/result_uart_tx.sv
// Queues classification results in a small FIFO and sends each one to the ESP32 as a framed
// 4-byte UART packet. The optional macro RESULT_TX_PARITY_EN selects 8E1 framing; SEQ_W must be >= 5.
module result_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [15:0]                 baud_div,
    input  logic                        result_valid,
    input  logic [1:0]                  class_id,
    input  logic [7:0]                  confidence,
    input  logic                        alarm_active,
    input  logic                        overflow_clr,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef RESULT_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             overflow_q, overflow_d;

    logic [2:0]       state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [23:0]      pkt_q, pkt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef RESULT_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic        push_req, push_ok, pop, drop, bit_done;
    logic [15:0] push_entry, rd_entry;

    // Each entry already holds B1 and B2, so the sequence number is frozen at capture time.
    assign push_entry = {alarm_active, seq_q[4:0], class_id, confidence};
    assign rd_entry   = fifo_mem[rd_ptr_q];

    assign push_req = result_valid & enable;
    assign pop      = (state_q == S_IDLE) & enable & (count_q != '0);
    assign push_ok  = push_req & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);
    assign drop     = push_req & ~push_ok;
    assign bit_done = (cnt_q == baud_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            seq_d    = seq_q + SEQ_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pkt_d      = pkt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
`ifdef RESULT_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? 16'd0 : cnt_q + 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d    = S_START;
                    baud_d     = baud_div;
                    cnt_d      = 16'd0;
                    byte_idx_d = 2'd0;
                    shift_d    = SYNC_BYTE;
                    pkt_d      = {SYNC_BYTE ^ rd_entry[15:8] ^ rd_entry[7:0], rd_entry[7:0], rd_entry[15:8]};
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
`ifdef RESULT_TX_PARITY_EN
                    par_d      = ^SYNC_BYTE;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef RESULT_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (byte_idx_q != 2'd3) begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                        shift_d    = pkt_q[7:0];
                        pkt_d      = {8'h00, pkt_q[23:8]};
`ifdef RESULT_TX_PARITY_EN
                        par_d      = ^pkt_q[7:0];
`endif
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= 16'd0;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 8'd0;
            pkt_q      <= 24'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef RESULT_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            pkt_q      <= pkt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef RESULT_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_result_uart_tx.sv
// Randomised bench for result_uart_tx: a transaction-level model queues expected bytes and a
// UART receiver process decodes uart_tx and checks every byte against that queue.
module tb_result_uart_tx;
    localparam int DEPTH = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         baud;
    } sbEntry_t;

    logic                    clk = 1'b0;
    logic                    rstN = 1'b1;
    logic                    enable = 1'b0;
    logic [15:0]             baudDiv = 16'd3;
    logic                    resultValid = 1'b0;
    logic [1:0]              classId = 2'd0;
    logic [7:0]              confidence = 8'd0;
    logic                    alarmActive = 1'b0;
    logic                    overflowClr = 1'b0;
    logic                    uartTx;
    logic                    busy;
    logic [$clog2(DEPTH):0]  fifoCount;
    logic                    overflow;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         busyEnd = 0;
    int         txFreeAt = 0;
    logic [4:0] mSeq = 5'd0;
    logic       mOvf = 1'b0;
    logic [15:0] mFifo[$];
    sbEntry_t   sbQ[$];
    bit         monOn = 1'b0;

    result_uart_tx #(.FIFO_DEPTH(DEPTH), .SEQ_W(5)) dut (
        .clk(clk), .rst_n(rstN), .enable(enable), .baud_div(baudDiv),
        .result_valid(resultValid), .class_id(classId), .confidence(confidence),
        .alarm_active(alarmActive), .overflow_clr(overflowClr),
        .uart_tx(uartTx), .busy(busy), .fifo_count(fifoCount), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Packet-level model: one pop per free transmitter, packet length from the bit count.
    task automatic modelStep();
        int         oldSize;
        bit         popNow;
        bit         drop;
        logic [15:0] e;
        logic [7:0] b1, b2;
        int         bd;
        oldSize = mFifo.size();
        popNow  = enable && (oldSize > 0) && (cyc >= txFreeAt);
        drop    = 1'b0;
        if (popNow) begin
            e  = mFifo.pop_front();
            b1 = e[15:8];
            b2 = e[7:0];
            bd = int'(baudDiv);
            sbQ.push_back('{8'hA5, bd});
            sbQ.push_back('{b1, bd});
            sbQ.push_back('{b2, bd});
            sbQ.push_back('{8'hA5 ^ b1 ^ b2, bd});
            busyEnd  = cyc + 4 * NBITS * (bd + 1);
            txFreeAt = busyEnd + 1;
        end
        if (enable && resultValid) begin
            if (oldSize < DEPTH || popNow) begin
                mFifo.push_back({alarmActive, mSeq, classId, confidence});
                mSeq = mSeq + 5'd1;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) mOvf = 1'b1;
        else if (overflowClr) mOvf = 1'b0;
    endtask

    task automatic checkOutput();
        bit expBusy;
        expBusy = (cyc < busyEnd);
        checkEq("fifo_count", int'(fifoCount), mFifo.size());
        checkEq("overflow", int'(overflow), int'(mOvf));
        checkEq("busy", int'(busy), int'(expBusy));
        if (!expBusy) checkEq("uart_tx_idle", int'(uartTx), 1);
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [7:0] cf,
                                 input logic a, input logic clr);
        resultValid = v;
        classId     = c;
        confidence  = cf;
        alarmActive = a;
        overflowClr = clr;
        @(posedge clk);
        cyc++;
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic pushRandom(input logic clr);
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), clr);
    endtask

    // Asserted mid-cycle so the asynchronous outputs are checked before any clock edge.
    task automatic applyReset();
        #2;
        rstN = 1'b0;
        monOn = 1'b1;
        #1;
        checkEq("reset_uart_tx", int'(uartTx), 1);
        checkEq("reset_busy", int'(busy), 0);
        checkEq("reset_fifo_count", int'(fifoCount), 0);
        checkEq("reset_overflow", int'(overflow), 0);
        mFifo.delete();
        sbQ.delete();
        mSeq = 5'd0;
        mOvf = 1'b0;
        busyEnd = 0;
        txFreeAt = 0;
        resultValid = 1'b0;
        overflowClr = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #3;
        rstN = 1'b1;
        @(posedge clk);
        cyc++;
        modelStep();
        #1;
        checkOutput();
    endtask

    int         rxJ, rxBit, rxBaud;
    logic [7:0] rxData;
    logic       rxPar;
    bit         rxActive = 1'b0;
    sbEntry_t   rxExp;

    // UART receiver: start detected on the first low sample, then each bit sampled mid-period.
    always @(negedge clk) begin
        if (!rstN || !monOn) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (uartTx == 1'b0) begin
                rxActive = 1'b1;
                rxJ = 1;
                rxBit = 1;
                rxData = 8'd0;
                rxPar = 1'b0;
                rxBaud = (sbQ.size() > 0) ? sbQ[0].baud : int'(baudDiv);
            end
        end else begin
            rxJ++;
            if (rxJ == rxBit * (rxBaud + 1) + (rxBaud + 1) / 2 + 1) begin
                if (rxBit <= 8) begin
                    rxData[rxBit-1] = uartTx;
                end else if (rxBit < NBITS - 1) begin
                    rxPar = uartTx;
                end else begin
                    if (sbQ.size() == 0) begin
                        checkEq("unexpected_byte", int'(rxData), -1);
                    end else begin
                        rxExp = sbQ.pop_front();
                        checkEq("rx_byte", int'(rxData), int'(rxExp.data));
                    end
                    checkEq("stop_bit", int'(uartTx), 1);
`ifdef RESULT_TX_PARITY_EN
                    checkEq("parity_bit", int'(rxPar), int'(^rxData));
`endif
                    rxActive = 1'b0;
                end
                rxBit++;
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        applyReset();
        enable = 1'b1;

        // Single result: A5 82 C8 EF at 4 clk/bit.
        baudDiv = 16'd3;
        applyStimulus(1'b1, 2'd2, 8'hC8, 1'b1, 1'b0);
        idle(170);

        // Six back-to-back pulses; the last also carries a clear, which the drop must override.
        for (int i = 0; i < 5; i++) pushRandom(1'b0);
        pushRandom(1'b1);
        idle(20);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        idle(850);

        // Reset while the second byte is being shifted.
        applyStimulus(1'b1, 2'd1, 8'h3C, 1'b0, 1'b0);
        idle(55);
        applyReset();
        applyStimulus(1'b1, 2'd3, 8'h5A, 1'b1, 1'b0);
        idle(170);

        // Enable dropped during the third byte of the first of two packets.
        pushRandom(1'b0);
        pushRandom(1'b0);
        idle(90);
        enable = 1'b0;
        idle(250);
        enable = 1'b1;
        idle(200);

        // Sequence wrap at the fastest bit rate.
        baudDiv = 16'd0;
        for (int i = 0; i < 33; i++) begin
            pushRandom(1'b0);
            idle(41);
        end
        idle(10);

        // Divisor changed mid-packet only affects the following packet.
        baudDiv = 16'd3;
        idle(2);
        pushRandom(1'b0);
        pushRandom(1'b0);
        idle(30);
        baudDiv = 16'd7;
        idle(500);

        // Random traffic with enable, clear and divisor changes.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 149) == 0) baudDiv = 16'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 14) == 0), 2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 29) == 0));
        end
        enable = 1'b1;
        for (int i = 0; i < 4000 && (mFifo.size() > 0 || cyc <= busyEnd + 2); i++) idle(1);
        idle(5);
        checkEq("drained_model_fifo", mFifo.size(), 0);
        checkEq("drained_scoreboard", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Downstream consumer of the NN/alarm stage. It captures each completed classification (class_id, confidence, alarm state) into a small FIFO and serialises it as a 4-byte framed packet on the UART TX GPIO to the companion ESP32. It replaces the constant-idle TX pin drive with hardware-generated result reporting. Bit rate is programmable via a Wishbone-supplied divisor.

Parameters:
FIFO_DEPTH, 4, result entries buffered; power of 2, minimum 2
SEQ_W, 5, width of the per-packet sequence counter

Ports:
clk  input  1  system clock (wb_clk_i domain)
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
enable  input  1  global enable from WB control register
baud_div  input  16  bit period minus one, in clk cycles
result_valid  input  1  single-cycle pulse, asserted on nn_done
class_id  input  2  classification result
confidence  input  8  classification confidence
alarm_active  input  1  alarm state sampled with result
overflow_clr  input  1  pulse; clears overflow
uart_tx  output  1  serial output, idle high, registered
busy  output  1  high while a packet is being shifted
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued
overflow  output  1  sticky; a result was dropped

Behaviour:
- Reset (async assertion, sync release): uart_tx=1, busy=0, fifo_count=0, overflow=0, seq=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; uart_tx goes high without waiting for a clock.
- Push: on a clk edge with result_valid=1 and enable=1, store {alarm_active, seq, class_id, confidence}; seq increments mod 2^SEQ_W (31 wraps to 0). result_valid is ignored while enable=0.
- Full: a push while fifo_count==FIFO_DEPTH and no same-cycle pop is dropped, overflow is set, and seq does not increment. A push and pop in the same cycle when full are both accepted; the count is unchanged.
- overflow_clr clears overflow. A same-cycle drop wins: overflow stays set.
- Packet bytes: B0=0xA5; B1={alarm, seq[4:0], class_id[1:0]}; B2=confidence; B3=B0^B1^B2.
- Frame: 8N1, LSB first. Each bit lasts baud_div+1 clocks. baud_div is latched at packet start; changes take effect on the next packet.
- FSM:
  - IDLE: if fifo non-empty and enable=1, pop the entry, latch the packet, set byte_idx=0, go to START. busy=1 from this edge.
  - START: uart_tx=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then STOP.
  - STOP: uart_tx=1 for one bit period. If byte_idx<3, increment it and go to START; otherwise go to IDLE with busy=0.
- Latency: result_valid is sampled at edge E with the FIFO empty and FSM in IDLE. The pop occurs at E+1, and uart_tx is low from E+1.
- Back-to-back packets: the next start bit follows the previous stop bit with no extra gap. IDLE spends exactly one cycle before the pop.
- enable falling mid-packet: the current packet completes all 4 bytes. No new packet starts while enable=0, and queued entries are retained.
- Bit counter and byte index never exceed range. No partial packets are emitted except on reset.

Optional Feature:
RESULT_TX_PARITY_EN
- Defined: an even-parity bit over the 8 data bits is inserted between DATA and STOP (8E1, 11 bit periods per byte). The state PARITY is added.
- Undefined: 8N1 exactly as above; no parity logic is synthesised.

Test Plan:
- Single result: baud_div=3, class_id=2, confidence=0xC8, alarm=1, first result -> bytes A5,82,C8,EF on uart_tx (4 clk/bit, 160 clk total); busy falls after the last stop bit; fifo_count returns to 0.
- Overflow: six result_valid pulses on consecutive cycles, FIFO_DEPTH=4 -> fifo_count peaks at 4 and the 6th result is dropped; overflow=1; five packets sent with seq 0-4. overflow_clr -> overflow=0.
- Reset mid-frame: assert rst_n low during DATA of B1 -> uart_tx=1 immediately (before the next edge); busy=0, fifo_count=0; the next result carries seq=0.
- Enable drop: two results queued, enable falls during B2 of the first packet -> the first packet completes, the second is held (fifo_count=1). Re-enable -> the second is sent with seq=1.
- Seq wrap: 33 results spaced one packet apart -> the 33rd packet has B1[6:2]=0.
- Baud change: alter baud_div from 3 to 7 mid-packet -> the current packet stays at 4 clk/bit; the next packet uses 8 clk/bit.
